// File: rtl/conv_window_addr_gen_if.sv
// Bundle between the layer controller and the sliding-window address generator.
// The controller (master) issues write/advance requests; the generator (slave)
// returns the write pointer, tap addresses and occupancy status.
interface conv_window_addr_gen_if #(
  parameter int ADDR_W = 4,
  parameter int TAPS   = 3,
  parameter int CNT_W  = 16
) ();
  logic                     write_en;
  logic                     read_en;
  logic [ADDR_W-1:0]        write_addr;
  logic [TAPS*ADDR_W-1:0]   read_addr;
  logic                     window_valid;
  logic                     full;
  logic [ADDR_W:0]          occupancy;
  logic [CNT_W-1:0]         win_count;

  modport master (
    output write_en, read_en,
    input  write_addr, read_addr, window_valid, full, occupancy, win_count
  );

  modport slave (
    input  write_en, read_en,
    output write_addr, read_addr, window_valid, full, occupancy, win_count
  );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Sliding-window address generator over a circular register file.
// Produces one write pointer and TAPS read addresses (base + i) mod DEPTH,
// tracks unretired samples, and moves the window by STRIDE on each advance.
// Every output is a flop; next values are formed combinationally so the
// flags and taps land on the same edge as the counters they describe.
module conv_window_addr_gen #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int TAPS   = 3,
  parameter int STRIDE = 1,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  conv_window_addr_gen_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] TAPS_V   = (ADDR_W+1)'(TAPS);
  localparam logic [ADDR_W:0] STRIDE_V = (ADDR_W+1)'(STRIDE);
  localparam logic [ADDR_W:0] ONE_V    = (ADDR_W+1)'(1);

  // Modular add: a < DEPTH and inc <= DEPTH, so one conditional subtract suffices.
  function automatic logic [ADDR_W-1:0] wrapAdd(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W:0]   inc);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + inc;
    if (sum >= DEPTH_V) begin
      sum = sum - DEPTH_V;
    end else begin
      sum = sum;
    end
    return sum[ADDR_W-1:0];
  endfunction

  // Tap vector for base 0: tap i sits at address i.
  function automatic logic [TAPS*ADDR_W-1:0] initTaps();
    logic [TAPS*ADDR_W-1:0] v;
    v = {(TAPS*ADDR_W){1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      v[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
    end
    return v;
  endfunction

  localparam logic [TAPS*ADDR_W-1:0] TAPS_RST = initTaps();

  logic [ADDR_W-1:0]      wrPtr_r,     wrPtrNext_s;
  logic [ADDR_W-1:0]      base_r,      baseNext_s;
  logic [ADDR_W:0]        occ_r,       occNext_s;
  logic [CNT_W-1:0]       winCnt_r,    winCntNext_s;
  logic [TAPS*ADDR_W-1:0] taps_r,      tapsNext_s;
  logic                   winValid_r,  winValidNext_s;
  logic                   full_r,      fullNext_s;
  logic                   wrAcc_s;
  logic                   rdAcc_s;

  // A write is judged on the current full flag only; an advance needs a full window.
  assign wrAcc_s = bus.write_en & ~full_r;
  assign rdAcc_s = bus.read_en & winValid_r;

  // Next-state for pointers and counters; clear restarts everything.
  always_comb begin
    wrPtrNext_s  = wrPtr_r;
    baseNext_s   = base_r;
    occNext_s    = occ_r;
    winCntNext_s = winCnt_r;
    if (clear) begin
      wrPtrNext_s  = {ADDR_W{1'b0}};
      baseNext_s   = {ADDR_W{1'b0}};
      occNext_s    = {(ADDR_W+1){1'b0}};
      winCntNext_s = {CNT_W{1'b0}};
    end else begin
      if (wrAcc_s) begin
        wrPtrNext_s = wrapAdd(wrPtr_r, ONE_V);
      end else begin
        wrPtrNext_s = wrPtr_r;
      end
      if (rdAcc_s) begin
        baseNext_s   = wrapAdd(base_r, STRIDE_V);
        winCntNext_s = winCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        baseNext_s   = base_r;
        winCntNext_s = winCnt_r;
      end
      // rdAcc implies occ >= TAPS >= STRIDE, wrAcc implies occ < DEPTH: no under/overflow.
      occNext_s = occ_r + (wrAcc_s ? ONE_V : {(ADDR_W+1){1'b0}})
                        - (rdAcc_s ? STRIDE_V : {(ADDR_W+1){1'b0}});
    end
  end

  // Next tap addresses and status flags, derived from the next-state values.
  always_comb begin
    tapsNext_s = taps_r;
    for (int i = 0; i < TAPS; i++) begin
      tapsNext_s[i*ADDR_W +: ADDR_W] = wrapAdd(baseNext_s, (ADDR_W+1)'(i));
    end
    winValidNext_s = (occNext_s >= TAPS_V);
    fullNext_s     = (occNext_s == DEPTH_V);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_r    <= {ADDR_W{1'b0}};
      base_r     <= {ADDR_W{1'b0}};
      occ_r      <= {(ADDR_W+1){1'b0}};
      winCnt_r   <= {CNT_W{1'b0}};
      taps_r     <= TAPS_RST;
      winValid_r <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      wrPtr_r    <= wrPtrNext_s;
      base_r     <= baseNext_s;
      occ_r      <= occNext_s;
      winCnt_r   <= winCntNext_s;
      taps_r     <= tapsNext_s;
      winValid_r <= winValidNext_s;
      full_r     <= fullNext_s;
    end
  end

  assign bus.write_addr   = wrPtr_r;
  assign bus.read_addr    = taps_r;
  assign bus.window_valid = winValid_r;
  assign bus.full         = full_r;
  assign bus.occupancy    = occ_r;
  assign bus.win_count    = winCnt_r;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Directed bench for conv_window_addr_gen: default instance (STRIDE 1) and a
// STRIDE 2 instance sharing clock, reset and clear.
module tb_conv_window_addr_gen;
  logic clk;
  logic rst_n;
  logic clear;
  int   total;
  int   bad;

  conv_window_addr_gen_if #(.ADDR_W(4), .TAPS(3), .CNT_W(16)) a ();
  conv_window_addr_gen_if #(.ADDR_W(4), .TAPS(3), .CNT_W(16)) b ();

  conv_window_addr_gen #(.ADDR_W(4), .DEPTH(16), .TAPS(3), .STRIDE(1), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(a.slave));

  conv_window_addr_gen #(.ADDR_W(4), .DEPTH(16), .TAPS(3), .STRIDE(2), .CNT_W(16)) dutB (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b.slave));

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetA(input string tag);
    check({tag, ".waddr"}, 32'(a.write_addr), 32'h0);
    check({tag, ".taps"},  32'(a.read_addr), 32'h210);
    check({tag, ".wv"},    32'(a.window_valid), 32'h0);
    check({tag, ".full"},  32'(a.full), 32'h0);
    check({tag, ".occ"},   32'(a.occupancy), 32'h0);
    check({tag, ".wc"},    32'(a.win_count), 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    a.write_en = 1'b0; a.read_en = 1'b0;
    b.write_en = 1'b0; b.read_en = 1'b0;

    // Reset state
    tick(); tick();
    checkResetA("reset");
    rst_n = 1'b1;
    tick();
    checkResetA("idle");

    // Three writes, then one advance
    a.write_en = 1'b1;
    tick(); tick();
    check("wv_after2", 32'(a.window_valid), 32'h0);
    tick();
    a.write_en = 1'b0;
    check("wv_after3", 32'(a.window_valid), 32'h1);
    check("occ_after3", 32'(a.occupancy), 32'h3);
    check("waddr_after3", 32'(a.write_addr), 32'h3);
    a.read_en = 1'b1;
    tick();
    a.read_en = 1'b0;
    check("taps_adv1", 32'(a.read_addr), 32'h321);
    check("occ_adv1", 32'(a.occupancy), 32'h2);
    check("wc_adv1", 32'(a.win_count), 32'h1);
    check("wv_adv1", 32'(a.window_valid), 32'h0);
    // read with window_valid low is ignored
    a.read_en = 1'b1;
    tick();
    a.read_en = 1'b0;
    check("taps_ignored", 32'(a.read_addr), 32'h321);
    check("wc_ignored", 32'(a.win_count), 32'h1);

    // Plain clear back to reset state
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkResetA("clear1");

    // Fill to 16
    a.write_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        check("full_at15", 32'(a.full), 32'h0);
        check("occ_at15", 32'(a.occupancy), 32'hF);
      end
    end
    check("full_at16", 32'(a.full), 32'h1);
    check("occ_at16", 32'(a.occupancy), 32'h10);
    check("waddr_wrap", 32'(a.write_addr), 32'h0);
    tick();
    check("waddr_17th", 32'(a.write_addr), 32'h0);
    check("occ_17th", 32'(a.occupancy), 32'h10);
    a.read_en = 1'b1;
    tick();
    a.write_en = 1'b0;
    check("occ_rw_full", 32'(a.occupancy), 32'hF);
    check("waddr_rw_full", 32'(a.write_addr), 32'h0);
    check("taps_rw_full", 32'(a.read_addr), 32'h321);
    check("full_rw_full", 32'(a.full), 32'h0);

    // Drain to 3 with reads only (12 more advances, read_en still high)
    for (int k = 0; k < 12; k++) tick();
    a.read_en = 1'b0;
    check("occ_drain", 32'(a.occupancy), 32'h3);
    check("taps_drain", 32'(a.read_addr), 32'hFED);
    check("wc_drain", 32'(a.win_count), 32'd13);

    // Steady stream: write and read every cycle across the wrap
    a.write_en = 1'b1;
    a.read_en  = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("occ_stream", 32'(a.occupancy), 32'h3);
      if (k == 1) check("taps_wrap1", 32'(a.read_addr), 32'h0FE);
      if (k == 2) check("taps_wrap2", 32'(a.read_addr), 32'h10F);
    end
    check("wc_stream", 32'(a.win_count), 32'd30);
    check("waddr_stream", 32'(a.write_addr), 32'h1);
    check("taps_stream", 32'(a.read_addr), 32'h0FE);

    // clear wins over same-cycle write and read
    clear = 1'b1;
    tick();
    clear = 1'b0;
    a.write_en = 1'b0;
    a.read_en  = 1'b0;
    checkResetA("clear_rw");

    // STRIDE 2 instance: 4 writes then one advance
    b.write_en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    b.write_en = 1'b0;
    check("s2_occ4", 32'(b.occupancy), 32'h4);
    check("s2_wv4", 32'(b.window_valid), 32'h1);
    b.read_en = 1'b1;
    tick();
    b.read_en = 1'b0;
    check("s2_taps", 32'(b.read_addr), 32'h432);
    check("s2_occ", 32'(b.occupancy), 32'h2);
    check("s2_wv", 32'(b.window_valid), 32'h0);
    check("s2_wc", 32'(b.win_count), 32'h1);

    // Asynchronous reset between edges
    a.write_en = 1'b1;
    tick();
    a.write_en = 1'b0;
    check("pre_rst_waddr", 32'(a.write_addr), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetA("async_rst");
    check("async_rst_b_occ", 32'(b.occupancy), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    checkResetA("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
